// File: rtl/fan_ctrl_pkg.sv
// Shared types, widths and default limits for the fan-curve governor.
package fan_ctrl_pkg;

  localparam int unsigned RPM_W   = 13;
  localparam int unsigned TEMP_W  = 8;
  localparam int unsigned FAN_W   = 16;
  localparam int unsigned WDT_W   = 19;
  localparam int unsigned CNT_W   = 8;
  localparam int unsigned STALL_W = 8;

  localparam int          DEF_T_LOW        = 30;
  localparam int          DEF_T_HIGH       = 70;
  localparam int          DEF_T_CRIT       = 85;
  localparam int          DEF_HYST         = 3;
  localparam int unsigned DEF_RPM_MIN      = 1200;
  localparam int unsigned DEF_RPM_MAX      = 6000;
  localparam int unsigned DEF_RAMP_STEP    = 300;
  localparam int unsigned DEF_STALL_LIMIT  = 3;
  localparam int unsigned DEF_SENS_TIMEOUT = 400000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EVAL,
    ST_MAP,
    ST_RAMP,
    ST_ISSUE
  } state_e;

  // Move cur toward tgt by at most step.
  function automatic logic [RPM_W-1:0] ramp_toward(input logic [RPM_W-1:0] cur,
                                                   input logic [RPM_W-1:0] tgt,
                                                   input logic [RPM_W-1:0] step);
    logic [RPM_W-1:0] diff;
    if (tgt >= cur) begin
      diff = tgt - cur;
      return (diff > step) ? RPM_W'(cur + step) : tgt;
    end
    diff = cur - tgt;
    return (diff > step) ? RPM_W'(cur - step) : tgt;
  endfunction

endpackage

// File: rtl/fan_curve_map.sv
// Combinational piecewise-linear temperature to fan-speed target map.
module fan_curve_map
  import fan_ctrl_pkg::*;
#(
  parameter int          T_LOW   = DEF_T_LOW,
  parameter int          T_HIGH  = DEF_T_HIGH,
  parameter int unsigned RPM_MIN = DEF_RPM_MIN,
  parameter int unsigned RPM_MAX = DEF_RPM_MAX
) (
  input  logic signed [TEMP_W-1:0] i_temp,
  output logic        [RPM_W-1:0]  o_target_c
);

  localparam int unsigned PROD_W   = 24;
  localparam int unsigned RPM_SPAN = RPM_MAX - RPM_MIN;
  localparam int unsigned T_SPAN   = 32'(T_HIGH - T_LOW);

  logic [PROD_W-1:0] w_delta;
  logic [PROD_W-1:0] w_scaled;

  // Interpolated value is only selected strictly between the thresholds.
  always_comb begin
    w_delta    = PROD_W'(int'(i_temp) - T_LOW);
    w_scaled   = (w_delta * PROD_W'(RPM_SPAN)) / PROD_W'(T_SPAN);
    o_target_c = RPM_W'(RPM_MIN) + RPM_W'(w_scaled);
    if (int'(i_temp) <= T_LOW) begin
      o_target_c = RPM_W'(RPM_MIN);
    end else if (int'(i_temp) >= T_HIGH) begin
      o_target_c = RPM_W'(RPM_MAX);
    end
  end

endmodule

// File: rtl/fan_curve_ctrl.sv
// Slew-limited fan-speed governor with over-temperature, stall and sensor watchdog flags.
module fan_curve_ctrl
  import fan_ctrl_pkg::*;
#(
  parameter int          T_LOW        = DEF_T_LOW,
  parameter int          T_HIGH       = DEF_T_HIGH,
  parameter int          T_CRIT       = DEF_T_CRIT,
  parameter int          HYST         = DEF_HYST,
  parameter int unsigned RPM_MIN      = DEF_RPM_MIN,
  parameter int unsigned RPM_MAX      = DEF_RPM_MAX,
  parameter int unsigned RAMP_STEP    = DEF_RAMP_STEP,
  parameter int unsigned STALL_LIMIT  = DEF_STALL_LIMIT,
  parameter int unsigned SENS_TIMEOUT = DEF_SENS_TIMEOUT
) (
  input  logic              CLK_400K,
  input  logic              RESET_N,
  input  logic              SENS_DONE,
  input  logic              TEMP_BUSY,
  input  logic [TEMP_W-1:0] LOCT1_H,
  input  logic [TEMP_W-1:0] REMT1_H,
  input  logic [FAN_W-1:0]  FAN_RPM,
  output logic [RPM_W-1:0]  SPEED_RPM,
  output logic              BUSY_GO_HI,
  output logic              OVERTEMP,
  output logic              FAN_FAULT,
  output logic              SENSOR_FAULT,
  output logic [TEMP_W-1:0] T_MAX,
  output logic [CNT_W-1:0]  UPDATE_CNT
);

  state_e                   r_state, w_state_nxt;
  logic                     r_sd_q;
  logic [RPM_W-1:0]         r_speed, w_speed_nxt;
  logic [RPM_W-1:0]         r_target, w_target_nxt;
  logic                     r_busy, w_busy_nxt;
  logic                     r_otemp, w_otemp_nxt;
  logic                     r_ffault, w_ffault_nxt;
  logic                     r_sfault, w_sfault_nxt;
  logic signed [TEMP_W-1:0] r_tmax, w_tmax_nxt;
  logic [CNT_W-1:0]         r_upd, w_upd_nxt;
  logic [STALL_W-1:0]       r_stall, w_stall_nxt;
  logic [WDT_W-1:0]         r_wdt, w_wdt_nxt;
  logic                     r_boot, w_boot_nxt;
  logic                     w_rise;
  logic [RPM_W-1:0]         w_map_target;

  assign w_rise = SENS_DONE & ~r_sd_q;

  fan_curve_map #(
    .T_LOW  (T_LOW),
    .T_HIGH (T_HIGH),
    .RPM_MIN(RPM_MIN),
    .RPM_MAX(RPM_MAX)
  ) u_map (
    .i_temp    (r_tmax),
    .o_target_c(w_map_target)
  );

  always_ff @(posedge CLK_400K or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state  <= ST_IDLE;
      r_sd_q   <= 1'b0;
      r_speed  <= RPM_W'(RPM_MAX);
      r_target <= RPM_W'(RPM_MAX);
      r_busy   <= 1'b0;
      r_otemp  <= 1'b0;
      r_ffault <= 1'b0;
      r_sfault <= 1'b0;
      r_tmax   <= '0;
      r_upd    <= '0;
      r_stall  <= '0;
      r_wdt    <= '0;
      r_boot   <= 1'b1;
    end else begin
      r_state  <= w_state_nxt;
      r_sd_q   <= SENS_DONE;
      r_speed  <= w_speed_nxt;
      r_target <= w_target_nxt;
      r_busy   <= w_busy_nxt;
      r_otemp  <= w_otemp_nxt;
      r_ffault <= w_ffault_nxt;
      r_sfault <= w_sfault_nxt;
      r_tmax   <= w_tmax_nxt;
      r_upd    <= w_upd_nxt;
      r_stall  <= w_stall_nxt;
      r_wdt    <= w_wdt_nxt;
      r_boot   <= w_boot_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_speed_nxt  = r_speed;
    w_target_nxt = r_target;
    w_busy_nxt   = r_busy;
    w_otemp_nxt  = r_otemp;
    w_ffault_nxt = r_ffault;
    w_sfault_nxt = r_sfault;
    w_tmax_nxt   = r_tmax;
    w_upd_nxt    = r_upd;
    w_stall_nxt  = r_stall;
    w_wdt_nxt    = r_wdt;
    w_boot_nxt   = r_boot;

    unique case (r_state)
      ST_IDLE: begin
        if (w_rise) w_state_nxt = ST_EVAL;
      end
      ST_EVAL: begin
        // First frame after reset precedes any sensor read: release at full speed.
        if (r_boot) begin
          w_boot_nxt  = 1'b0;
          w_speed_nxt = RPM_W'(RPM_MAX);
          w_state_nxt = ST_ISSUE;
        end else if (TEMP_BUSY) begin
          w_state_nxt = ST_ISSUE;
        end else begin
          w_tmax_nxt   = ($signed(LOCT1_H) > $signed(REMT1_H)) ? $signed(LOCT1_H)
                                                               : $signed(REMT1_H);
          w_sfault_nxt = 1'b0;
          w_state_nxt  = ST_MAP;
        end
      end
      ST_MAP: begin
        w_target_nxt = w_map_target;
        if (int'(r_tmax) >= T_CRIT) begin
          w_otemp_nxt = 1'b1;
        end else if (int'(r_tmax) < T_CRIT - HYST) begin
          w_otemp_nxt = 1'b0;
        end
        w_state_nxt = ST_RAMP;
      end
      ST_RAMP: begin
        w_speed_nxt = r_otemp ? RPM_W'(RPM_MAX)
                              : ramp_toward(r_speed, r_target, RPM_W'(RAMP_STEP));
        if (r_speed >= RPM_W'(RPM_MIN) && FAN_RPM == '0) begin
          if (r_stall < STALL_W'(STALL_LIMIT)) w_stall_nxt = r_stall + 1'b1;
          w_ffault_nxt = (w_stall_nxt == STALL_W'(STALL_LIMIT));
        end else begin
          w_stall_nxt  = '0;
          w_ffault_nxt = 1'b0;
        end
        w_state_nxt = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (!r_busy) begin
          w_busy_nxt = 1'b1;
          w_upd_nxt  = r_upd + 1'b1;
        end else if (!SENS_DONE) begin
          w_busy_nxt  = 1'b0;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    // Watchdog overrides the FSM in the cycle it expires.
    if (w_rise) begin
      w_wdt_nxt = '0;
    end else if (r_wdt < WDT_W'(SENS_TIMEOUT - 1)) begin
      w_wdt_nxt = r_wdt + 1'b1;
      if (w_wdt_nxt == WDT_W'(SENS_TIMEOUT - 1)) begin
        w_sfault_nxt = 1'b1;
        w_speed_nxt  = RPM_W'(RPM_MAX);
      end
    end
  end

  assign SPEED_RPM    = r_speed;
  assign BUSY_GO_HI   = r_busy;
  assign OVERTEMP     = r_otemp;
  assign FAN_FAULT    = r_ffault;
  assign SENSOR_FAULT = r_sfault;
  assign T_MAX        = r_tmax;
  assign UPDATE_CNT   = r_upd;

endmodule

// File: tb/tb_fan_curve_ctrl.sv
// Scoreboard bench for fan_curve_ctrl against an arithmetic reference model.
module tb_fan_curve_ctrl;

  localparam int TO = 3000;

  logic        CLK_400K = 1'b0;
  logic        RESET_N = 1'b0;
  logic        SENS_DONE = 1'b0;
  logic        TEMP_BUSY = 1'b0;
  logic [7:0]  LOCT1_H = '0;
  logic [7:0]  REMT1_H = '0;
  logic [15:0] FAN_RPM = 16'd3000;
  logic [12:0] SPEED_RPM;
  logic        BUSY_GO_HI, OVERTEMP, FAN_FAULT, SENSOR_FAULT;
  logic [7:0]  T_MAX, UPDATE_CNT;

  fan_curve_ctrl #(.SENS_TIMEOUT(TO)) dut (
    .CLK_400K(CLK_400K), .RESET_N(RESET_N), .SENS_DONE(SENS_DONE), .TEMP_BUSY(TEMP_BUSY),
    .LOCT1_H(LOCT1_H), .REMT1_H(REMT1_H), .FAN_RPM(FAN_RPM), .SPEED_RPM(SPEED_RPM),
    .BUSY_GO_HI(BUSY_GO_HI), .OVERTEMP(OVERTEMP), .FAN_FAULT(FAN_FAULT),
    .SENSOR_FAULT(SENSOR_FAULT), .T_MAX(T_MAX), .UPDATE_CNT(UPDATE_CNT)
  );

  always #5 CLK_400K = ~CLK_400K;

  int cyc = 0;
  always @(posedge CLK_400K) cyc <= cyc + 1;

  typedef struct {
    int speed; int ot; int ff; int sf; int tmax; int upd; int cyc;
  } exp_t;
  exp_t sb[$];

  int n_vec = 0, n_err = 0;
  int m_speed, m_ot, m_ff, m_sf, m_tmax, m_upd, m_stall, m_boot, last_e;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int curve(input int t);
    if (t <= 30) return 1200;
    if (t >= 70) return 6000;
    return 1200 + ((t - 30) * 4800) / 40;
  endfunction

  task automatic model_reset();
    m_speed = 6000; m_ot = 0; m_ff = 0; m_sf = 0; m_tmax = 0;
    m_upd = 0; m_stall = 0; m_boot = 1;
  endtask

  // Drive one frame and push the model's expected response.
  task automatic start_frame(input byte loc, input byte rem, input int fan, input bit tbusy);
    exp_t e;
    int lat, tgt, t;
    @(negedge CLK_400K);
    LOCT1_H = loc; REMT1_H = rem; FAN_RPM = 16'(fan); TEMP_BUSY = tbusy;
    SENS_DONE = 1'b1;
    last_e = cyc + 1;
    if (m_boot != 0) begin
      m_boot = 0; m_speed = 6000; lat = 2;
    end else if (tbusy) begin
      lat = 2;
    end else begin
      t = (int'(loc) > int'(rem)) ? int'(loc) : int'(rem);
      m_tmax = t; m_sf = 0;
      tgt = curve(t);
      if (t >= 85) m_ot = 1;
      else if (t < 82) m_ot = 0;
      if (m_speed >= 1200 && fan == 0) begin
        m_stall = (m_stall < 3) ? m_stall + 1 : 3;
        m_ff = (m_stall == 3) ? 1 : 0;
      end else begin
        m_stall = 0; m_ff = 0;
      end
      if (m_ot != 0) m_speed = 6000;
      else if (tgt > m_speed) m_speed = m_speed + (((tgt - m_speed) > 300) ? 300 : tgt - m_speed);
      else m_speed = m_speed - (((m_speed - tgt) > 300) ? 300 : m_speed - tgt);
      lat = 4;
    end
    m_upd = (m_upd + 1) % 256;
    e.speed = m_speed; e.ot = m_ot; e.ff = m_ff; e.sf = m_sf;
    e.tmax = m_tmax; e.upd = m_upd; e.cyc = last_e + lat;
    sb.push_back(e);
  endtask

  task automatic wait_busy();
    for (int i = 0; i < 20 && !BUSY_GO_HI; i++) @(negedge CLK_400K);
    chk("busy_rise_timeout", int'(BUSY_GO_HI), 1);
  endtask

  task automatic finish_frame();
    int hold;
    hold = $urandom_range(0, 3);
    for (int i = 0; i < hold; i++) @(negedge CLK_400K);
    SENS_DONE = 1'b0;
    @(negedge CLK_400K);
    chk("busy_fall", int'(BUSY_GO_HI), 0);
    hold = $urandom_range(1, 8);
    for (int i = 0; i < hold; i++) @(negedge CLK_400K);
  endtask

  task automatic frame(input byte loc, input byte rem, input int fan, input bit tbusy);
    start_frame(loc, rem, fan, tbusy);
    wait_busy();
    finish_frame();
  endtask

  // Monitor: compare on every rising BUSY_GO_HI.
  initial begin
    exp_t e;
    logic busy_q;
    busy_q = 1'b0;
    forever begin
      @(negedge CLK_400K);
      if (BUSY_GO_HI && !busy_q) begin
        if (sb.size() == 0) begin
          chk("unexpected_update", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("latency", cyc, e.cyc);
          chk("speed", int'(SPEED_RPM), e.speed);
          chk("overtemp", int'(OVERTEMP), e.ot);
          chk("fan_fault", int'(FAN_FAULT), e.ff);
          chk("sensor_fault", int'(SENSOR_FAULT), e.sf);
          chk("t_max", int'($signed(T_MAX)), e.tmax);
          chk("update_cnt", int'(UPDATE_CNT), e.upd);
        end
      end
      busy_q = BUSY_GO_HI;
    end
  end

  initial begin
    int wd_target;
    byte l, r;
    model_reset();
    repeat (3) @(negedge CLK_400K);
    RESET_N = 1'b1;
    @(negedge CLK_400K);
    chk("rst_speed", int'(SPEED_RPM), 6000);
    chk("rst_busy", int'(BUSY_GO_HI), 0);
    chk("rst_flags", int'({OVERTEMP, FAN_FAULT, SENSOR_FAULT}), 0);
    chk("rst_tmax", int'(T_MAX), 0);
    chk("rst_cnt", int'(UPDATE_CNT), 0);

    frame(8'sd20, 8'sd20, 3000, 1'b0);
    repeat (9) frame(8'sd40, 8'sd50, 3000, 1'b0);
    repeat (10) frame(8'sd20, 8'sd25, 3000, 1'b0);
    frame(8'sd5, -8'sd10, 3000, 1'b0);
    frame(8'sd30, 8'sd86, 3000, 1'b0);
    frame(8'sd30, 8'sd83, 3000, 1'b0);
    frame(8'sd30, 8'sd81, 3000, 1'b0);
    repeat (9) frame(8'sd40, 8'sd50, 3000, 1'b0);
    repeat (3) frame(8'sd40, 8'sd50, 0, 1'b0);
    frame(8'sd40, 8'sd50, 2000, 1'b0);
    frame(8'sd90, 8'sd90, 2000, 1'b1);

    // Watchdog expires exactly TO-1 edges after the last frame edge.
    wd_target = last_e + TO - 2;
    while (cyc < wd_target) @(negedge CLK_400K);
    chk("wdt_before", int'(SENSOR_FAULT), 0);
    @(negedge CLK_400K);
    chk("wdt_fault", int'(SENSOR_FAULT), 1);
    chk("wdt_speed", int'(SPEED_RPM), 6000);
    m_sf = 1; m_speed = 6000;
    frame(8'sd40, 8'sd45, 3000, 1'b1);
    frame(8'sd40, 8'sd45, 3000, 1'b0);

    for (int k = 0; k < 150; k++) begin
      if ($urandom_range(0, 9) < 7) begin
        l = byte'($urandom_range(0, 100) - 10);
        r = byte'($urandom_range(0, 100) - 10);
      end else begin
        l = byte'($urandom_range(0, 255));
        r = byte'($urandom_range(0, 255));
      end
      frame(l, r, ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 7000)),
            ($urandom_range(0, 9) == 0));
    end

    // Asynchronous reset while the write phase is held.
    start_frame(8'sd60, 8'sd60, 3000, 1'b0);
    wait_busy();
    #2 RESET_N = 1'b0;
    #1;
    chk("async_rst_busy", int'(BUSY_GO_HI), 0);
    chk("async_rst_speed", int'(SPEED_RPM), 6000);
    chk("async_rst_cnt", int'(UPDATE_CNT), 0);
    SENS_DONE = 1'b0;
    model_reset();
    @(negedge CLK_400K);
    RESET_N = 1'b1;
    @(negedge CLK_400K);
    frame(8'sd60, 8'sd60, 3000, 1'b0);
    frame(8'sd60, 8'sd60, 3000, 1'b0);

    repeat (5) @(negedge CLK_400K);
    chk("scoreboard_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
